// File: rtl/io_mux_pkg.sv
// io_mux_pkg
// Shared types and constants for the runtime pad multiplexer.
//   pin_state_e   : per-pin state (ACTIVE drives the pad, DRAIN masks it)
//   DEF_*         : default parameter values used by io_mux_ctrl
//   FUNC_GPIO     : function index selected out of reset
//   fsel_width()  : width of a function-select field
//   addr_width()  : width of the register-port address (pins + lock slot)
package io_mux_pkg;

  typedef enum logic {
    ACTIVE = 1'b0,
    DRAIN  = 1'b1
  } pin_state_e;

  localparam int DEF_N_PINS      = 14;
  localparam int DEF_N_FUNC      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TURN_CYC    = 2;

  localparam int FUNC_GPIO = 0;

  // A single-function mux still needs a 1-bit select field.
  function automatic int fsel_width(input int n_func);
    return (n_func > 2) ? $clog2(n_func) : 1;
  endfunction

  // One extra address beyond the last pin is reserved for the lock register.
  function automatic int addr_width(input int n_pins);
    return $clog2(n_pins + 1);
  endfunction

endpackage

// File: rtl/io_mux_pin.sv
// io_mux_pin
// One muxed pad: function-select register, turnaround drain FSM and input
// synchroniser.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en      : accepted, validated write aimed at this pin
//   wr_fsel    : function select being written
//   func_o     : per-function output value for this pin
//   func_oe    : per-function output enable for this pin
//   pad_i      : raw pad input
//   pad_o      : pad drive value
//   pad_oe     : pad output enable
//   func_i     : synchronised input, routed only to the selected function
//   fsel       : current function select
//   busy       : pin is draining after a function change
module io_mux_pin
  import io_mux_pkg::*;
#(
  parameter int N_FUNC      = DEF_N_FUNC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TURN_CYC    = DEF_TURN_CYC,
  parameter int FW          = fsel_width(DEF_N_FUNC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [FW-1:0]     wr_fsel,
  input  logic [N_FUNC-1:0] func_o,
  input  logic [N_FUNC-1:0] func_oe,
  input  logic              pad_i,
  output logic              pad_o,
  output logic              pad_oe,
  output logic [N_FUNC-1:0] func_i,
  output logic [FW-1:0]     fsel,
  output logic              busy
);

  localparam int CW = $clog2(TURN_CYC + 1);

  pin_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          fsel_q, fsel_d;
  logic [SYNC_STAGES-1:0] sync_q;

  // State register, drain counter, select register and synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
      fsel_q  <= FW'(FUNC_GPIO);
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fsel_q  <= fsel_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  // A write during DRAIN always restarts the turnaround, even with an
  // unchanged select, so the pad stays masked TURN_CYC cycles after the
  // last write. Leaving DRAIN on the count-of-one cycle makes the mask
  // exactly TURN_CYC cycles long.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fsel_d  = fsel_q;
    case (state_q)
      ACTIVE: begin
        if (wr_en && (wr_fsel != fsel_q)) begin
          fsel_d  = wr_fsel;
          cnt_d   = CW'(TURN_CYC);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_en) begin
          fsel_d = wr_fsel;
          cnt_d  = CW'(TURN_CYC);
        end else if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  // Pad and input routing; everything is held at zero while draining.
  always_comb begin
    pad_o  = 1'b0;
    pad_oe = 1'b0;
    func_i = '0;
    if (state_q == ACTIVE) begin
      for (int f = 0; f < N_FUNC; f++) begin
        if (fsel_q == FW'(f)) begin
          pad_o     = func_o[f];
          pad_oe    = func_oe[f];
          func_i[f] = sync_q[SYNC_STAGES-1];
        end
      end
    end
  end

  assign fsel = fsel_q;
  assign busy = (state_q == DRAIN);

endmodule

// File: rtl/io_mux_ctrl.sv
// io_mux_ctrl
// Runtime-configurable pad multiplexer with a simple register port.
// Optional build macro: IO_MUX_LOCK_EN adds a sticky lock register at
// cfg_addr == N_PINS that blocks further function-select writes.
//   clk, rst          : clock, asynchronous active-high reset
//   cfg_req/we/addr   : register request, write flag, pin index (N_PINS = lock)
//   cfg_wdata         : function select to write
//   cfg_gnt           : grant, always equal to cfg_req
//   cfg_rvalid        : registered response strobe, one cycle after cfg_req
//   cfg_rdata         : {busy, fsel} of the addressed pin
//   cfg_err           : bad address, bad select, or locked
//   func_o_i/oe_i     : per-function outputs, index f*N_PINS+p
//   func_i_o          : synchronised pad inputs, index f*N_PINS+p
//   pad_o/pad_oe/pad_i: tristate pad cell interface
module io_mux_ctrl
  import io_mux_pkg::*;
#(
  parameter int N_PINS      = DEF_N_PINS,
  parameter int N_FUNC      = DEF_N_FUNC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TURN_CYC    = DEF_TURN_CYC,
  localparam int AW         = addr_width(N_PINS),
  localparam int FW         = fsel_width(N_FUNC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_req,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [FW-1:0]            cfg_wdata,
  output logic                     cfg_gnt,
  output logic                     cfg_rvalid,
  output logic [FW:0]              cfg_rdata,
  output logic                     cfg_err,
  input  logic [N_FUNC*N_PINS-1:0] func_o_i,
  input  logic [N_FUNC*N_PINS-1:0] func_oe_i,
  output logic [N_FUNC*N_PINS-1:0] func_i_o,
  output logic [N_PINS-1:0]        pad_o,
  output logic [N_PINS-1:0]        pad_oe,
  input  logic [N_PINS-1:0]        pad_i
);

  logic [N_PINS-1:0][N_FUNC-1:0] pin_func_o, pin_func_oe, pin_func_i;
  logic [N_PINS-1:0][FW-1:0]     pin_fsel;
  logic [N_PINS-1:0]             pin_busy;
  logic [N_PINS-1:0]             pin_wr_en;

  logic          addr_is_pin, wdata_ok, wr_ok;
  logic          lock_q, is_lock_addr;
  logic [FW:0]   rsp_data_d;
  logic          rsp_err_d;

  assign cfg_gnt     = cfg_req;
  assign addr_is_pin = (cfg_addr < AW'(N_PINS));
  // Widened by one bit so the compare stays meaningful for power-of-2 N_FUNC.
  assign wdata_ok    = ({1'b0, cfg_wdata} < (FW+1)'(N_FUNC));

`ifdef IO_MUX_LOCK_EN
  assign is_lock_addr = (cfg_addr == AW'(N_PINS));

  // Sticky lock, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (cfg_req && cfg_we && is_lock_addr) begin
      lock_q <= 1'b1;
    end
  end
`else
  assign is_lock_addr = 1'b0;
  assign lock_q       = 1'b0;
`endif

  assign wr_ok = cfg_req && cfg_we && addr_is_pin && wdata_ok && !lock_q;

  // Response decode; the result is registered below.
  always_comb begin
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    if (cfg_req) begin
      if (addr_is_pin) begin
        if (cfg_we) begin
          rsp_err_d = !wdata_ok || lock_q;
        end else begin
          for (int p = 0; p < N_PINS; p++) begin
            if (cfg_addr == AW'(p)) begin
              rsp_data_d = {pin_busy[p], pin_fsel[p]};
            end
          end
        end
      end else if (is_lock_addr) begin
        if (!cfg_we) begin
          rsp_data_d = {{FW{1'b0}}, lock_q};
        end
      end else begin
        rsp_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_rvalid <= cfg_req;
      cfg_rdata  <= rsp_data_d;
      cfg_err    <= rsp_err_d;
    end
  end

  for (genvar p = 0; p < N_PINS; p++) begin : g_pin
    for (genvar f = 0; f < N_FUNC; f++) begin : g_func
      assign pin_func_o[p][f]       = func_o_i[f*N_PINS+p];
      assign pin_func_oe[p][f]      = func_oe_i[f*N_PINS+p];
      assign func_i_o[f*N_PINS+p]   = pin_func_i[p][f];
    end

    assign pin_wr_en[p] = wr_ok && (cfg_addr == AW'(p));

    io_mux_pin #(
      .N_FUNC     (N_FUNC),
      .SYNC_STAGES(SYNC_STAGES),
      .TURN_CYC   (TURN_CYC),
      .FW         (FW)
    ) u_pin (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (pin_wr_en[p]),
      .wr_fsel(cfg_wdata),
      .func_o (pin_func_o[p]),
      .func_oe(pin_func_oe[p]),
      .pad_i  (pad_i[p]),
      .pad_o  (pad_o[p]),
      .pad_oe (pad_oe[p]),
      .func_i (pin_func_i[p]),
      .fsel   (pin_fsel[p]),
      .busy   (pin_busy[p])
    );
  end

endmodule

// File: tb/tb_io_mux_ctrl.sv
// tb_io_mux_ctrl
// Randomised bench for io_mux_ctrl against a cycle-level behavioural model:
// per-pin select and remaining-mask counts, a queue of past pad samples and
// the lock flag.
module tb_io_mux_ctrl;
  import io_mux_pkg::*;

  localparam int N_PINS      = 14;
  localparam int N_FUNC      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TURN_CYC    = 2;
  localparam int AW          = addr_width(N_PINS);
  localparam int FW          = fsel_width(N_FUNC);
  localparam int NB          = N_FUNC * N_PINS;
`ifdef IO_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_req = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [FW-1:0]     cfg_wdata = '0;
  logic              cfg_gnt;
  logic              cfg_rvalid;
  logic [FW:0]       cfg_rdata;
  logic              cfg_err;
  logic [NB-1:0]     func_o_i = '0;
  logic [NB-1:0]     func_oe_i = '0;
  logic [NB-1:0]     func_i_o;
  logic [N_PINS-1:0] pad_o;
  logic [N_PINS-1:0] pad_oe;
  logic [N_PINS-1:0] pad_i = '0;

  io_mux_ctrl #(
    .N_PINS(N_PINS), .N_FUNC(N_FUNC),
    .SYNC_STAGES(SYNC_STAGES), .TURN_CYC(TURN_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_gnt(cfg_gnt), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .func_o_i(func_o_i), .func_oe_i(func_oe_i), .func_i_o(func_i_o),
    .pad_o(pad_o), .pad_oe(pad_oe), .pad_i(pad_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int                fsel_m [N_PINS];
  int                mask_m [N_PINS];
  bit                lock_m;
  logic [N_PINS-1:0] sync_hist[$];
  bit                exp_rvalid;
  int                exp_rdata;
  bit                exp_err;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int p = 0; p < N_PINS; p++) begin
      fsel_m[p] = 0;
      mask_m[p] = 0;
    end
    lock_m = 1'b0;
    sync_hist.delete();
    for (int s = 0; s < SYNC_STAGES; s++) sync_hist.push_back('0);
    exp_rvalid = 1'b0;
    exp_rdata  = 0;
    exp_err    = 1'b0;
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic checkAll(input string phase);
    logic [N_PINS-1:0] e_o, e_oe;
    logic [NB-1:0]     e_fi;
    logic [N_PINS-1:0] synced;
    synced = sync_hist[0];
    e_o = '0; e_oe = '0; e_fi = '0;
    for (int p = 0; p < N_PINS; p++) begin
      if (mask_m[p] == 0) begin
        e_o[p]  = func_o_i[fsel_m[p]*N_PINS + p];
        e_oe[p] = func_oe_i[fsel_m[p]*N_PINS + p];
        e_fi[fsel_m[p]*N_PINS + p] = synced[p];
      end
    end
    checkOutput({phase, ".pad_o"},    64'(pad_o),    64'(e_o));
    checkOutput({phase, ".pad_oe"},   64'(pad_oe),   64'(e_oe));
    checkOutput({phase, ".func_i_o"}, 64'(func_i_o), 64'(e_fi));
    checkOutput({phase, ".gnt"},      64'(cfg_gnt),  64'(cfg_req));
    checkOutput({phase, ".rvalid"},   64'(cfg_rvalid), 64'(exp_rvalid));
    checkOutput({phase, ".rdata"},    64'(cfg_rdata),  64'(exp_rdata));
    checkOutput({phase, ".err"},      64'(cfg_err),    64'(exp_err));
  endtask

  // Called at a negedge: drive one request, check, advance the model to the
  // next edge, and return at the following negedge.
  task automatic applyStimulus(input bit req, input bit we, input int addr, input int wdata);
    bit wr_valid;
    cfg_req   = req;
    cfg_we    = we;
    cfg_addr  = AW'(addr);
    cfg_wdata = FW'(wdata);
    func_o_i  = NB'({$urandom(), $urandom()});
    func_oe_i = NB'({$urandom(), $urandom()});
    pad_i     = N_PINS'($urandom());
    #1;
    checkAll("run");

    exp_rvalid = req;
    exp_rdata  = 0;
    exp_err    = 1'b0;
    wr_valid   = 1'b0;
    if (req) begin
      if (addr < N_PINS) begin
        if (we) begin
          exp_err  = (wdata >= N_FUNC) || lock_m;
          wr_valid = !exp_err;
        end else begin
          exp_rdata = ((mask_m[addr] > 0) ? (1 << FW) : 0) + fsel_m[addr];
        end
      end else if (LOCK_EN && addr == N_PINS) begin
        if (we) lock_m = 1'b1;
        else    exp_rdata = int'(lock_m);
      end else begin
        exp_err = 1'b1;
      end
    end

    for (int p = 0; p < N_PINS; p++) begin
      if (wr_valid && addr == p && (mask_m[p] > 0 || wdata != fsel_m[p])) begin
        fsel_m[p] = wdata;
        mask_m[p] = TURN_CYC;
      end else if (!(wr_valid && addr == p) && mask_m[p] > 0) begin
        mask_m[p]--;
      end
    end
    sync_hist.push_back(pad_i);
    void'(sync_hist.pop_front());

    @(negedge clk);
  endtask

  // Asynchronous reset asserted away from any clock edge; checked before
  // the next edge, then held across two edges.
  task automatic doReset();
    cfg_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAll("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    doReset();

    // All pins on GPIO: read back every pin.
    for (int p = 0; p < N_PINS; p++) applyStimulus(1, 0, p, 0);

    // Single select change with read polling on the same pin.
    applyStimulus(1, 1, 5, 2);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 5, 0);

    // Back-to-back writes extend the drain; same-select rewrite is a no-op.
    applyStimulus(1, 1, 3, 1);
    applyStimulus(1, 1, 3, 3);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 3, 0);
    applyStimulus(1, 1, 3, 3);
    applyStimulus(1, 0, 3, 0);

    // Out-of-range address writes and reads.
    applyStimulus(1, 1, 15, 1);
    applyStimulus(1, 0, 15, 0);
    applyStimulus(1, 0, N_PINS, 0);

    // Idle cycles for the input path.
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);

    // Random traffic without locking.
    for (int i = 0; i < 600; i++) begin
      int a;
      bit we;
      a  = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      we = $urandom_range(0, 1);
      if (a == N_PINS) we = 1'b0;
      applyStimulus($urandom_range(0, 3) != 0, we, a, $urandom_range(0, N_FUNC-1));
    end

    // Lock, attempt a write, then reset mid-drain and retry.
    applyStimulus(1, 1, N_PINS, 0);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, N_PINS, 0);
    applyStimulus(1, 1, 1, 2);
    doReset();
    applyStimulus(1, 1, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);

    // Fully random traffic including the lock address and a late reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) doReset();
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                    $urandom_range(0, 15), $urandom_range(0, N_FUNC-1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_mux_ctrl.md
Name: io_mux_ctrl

Overview:
Runtime-configurable pad multiplexer. It replaces compile-time per-pin function defines with per-pin function-select registers written over a simple register port. Each pin chooses one of N_FUNC peripheral functions; function 0 is GPIO. It adds input synchronisation and a turnaround drain that tristates a pin when its function changes. It sits between the peripheral subsystem and the top-level tristate pad cells.

Parameters:
N_PINS, 14, number of muxed pins
N_FUNC, 4, functions per pin; function 0 is the reset default (GPIO)
SYNC_STAGES, 2, flop stages on each pad input (≥2)
TURN_CYC, 2, cycles pad_oe is forced low after a function change (≥1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg_req  in  1  register access request
cfg_we  in  1  1 = write, 0 = read
cfg_addr  in  AW=$clog2(N_PINS+1)  pin index; N_PINS = lock register
cfg_wdata  in  FW=$clog2(N_FUNC)  function select to write
cfg_gnt  out  1  grant, equals cfg_req (combinational)
cfg_rvalid  out  1  response valid, one cycle after an accepted request
cfg_rdata  out  FW+1  {busy, fsel} of the addressed pin
cfg_err  out  1  qualified by cfg_rvalid; bad address, bad fsel, or locked
func_o_i  in  N_FUNC*N_PINS  per-function output value, index f*N_PINS+p
func_oe_i  in  N_FUNC*N_PINS  per-function output enable
func_i_o  out  N_FUNC*N_PINS  synchronised pad input routed to the selected function
pad_o  out  N_PINS  pad drive value
pad_oe  out  N_PINS  pad output enable
pad_i  in  N_PINS  raw pad input

Behaviour:
- Reset, asynchronous, applied immediately: every fsel=0, every pin ACTIVE, drain counters 0, sync flops 0, cfg_rvalid=0, cfg_rdata=0, cfg_err=0, lock=0.
- Reset mid-drain: the pin returns to ACTIVE with fsel=0 at once.
- Per-pin FSM, ACTIVE:
  - pad_o = func_o_i[fsel], pad_oe = func_oe_i[fsel], combinational from the registered fsel.
  - A write with a new fsel different from the current one updates fsel, loads the counter with TURN_CYC and moves to DRAIN on the next edge.
  - A write with the same fsel is a no-op (no drain, no error).
- Per-pin FSM, DRAIN:
  - pad_oe=0, pad_o=0, all func_i_o bits for that pin =0.
  - Counter decrements each cycle; on reaching 0 the pin returns to ACTIVE, so the pin is masked for exactly TURN_CYC cycles.
  - A write during DRAIN updates fsel and reloads the counter to TURN_CYC; the last write wins.
- Input path: pad_i[p] passes through SYNC_STAGES flops. func_i_o[f*N_PINS+p] = sync[p] when fsel==f and the pin is ACTIVE, else 0. Latency from pad_i to func_i_o is SYNC_STAGES cycles.
- Register port:
  - Single-cycle accept. The response is registered: cfg_rvalid is high for one cycle after each cfg_req.
  - Read: cfg_rdata = {busy = pin in DRAIN, fsel}, cfg_err=0.
  - Write: cfg_rdata = 0.
  - cfg_addr ≥ N_PINS (excluding the lock address when the lock feature is compiled in): cfg_err=1, cfg_rdata=0, no state change.
  - Write with cfg_wdata ≥ N_FUNC (possible when N_FUNC is not a power of 2): cfg_err=1, fsel unchanged.
- Back-to-back requests: one response per cycle, with no stall.

Optional Feature:
IO_MUX_LOCK_EN
- Defined: a write of any data to cfg_addr = N_PINS sets a sticky lock bit, cleared only by rst. While locked, every fsel write is ignored and returns cfg_err=1; reads still work. A read of the lock address returns {0…, lock}.
- Undefined: no lock register. cfg_addr = N_PINS returns cfg_err=1 like any other out-of-range address.

Decomposition:
- Package io_mux_pkg holds: the pin-state enum (ACTIVE, DRAIN), default parameter constants, the FW/AW width functions, and the function-index constants (FUNC_GPIO=0).
- One sub-module, io_mux_pin: holds the per-pin fsel register, drain FSM/counter and sync chain. It is instantiated N_PINS times in a generate loop.
- The top level holds the register-port decode, the response register and the lock bit.

Test Plan:
1. Reset → all pads follow function 0. Drive func_o_i[p]=1 and func_oe_i[p]=1 for f=0 → pad_oe=all 1s, pad_o=all 1s. Reads of pins 0..13 return 0x0 (3-bit rdata).
2. Write pin 5 fsel=2 → rdata busy=1 for 2 cycles. pad_oe[5]=0 for exactly 2 cycles, then pad follows func 2. Pins ≠5 unaffected.
3. Write pin 3 fsel=1, then 1 cycle later fsel=3 → drain extends to 2 cycles after the second write. The final read returns {0,3}.
4. Toggle pad_i[7] with pin 7 at fsel=0 → func_i_o[7] follows after 2 cycles; func_i_o[N_PINS+7] stays 0.
5. cfg_addr=15 write → cfg_err=1 and no pin changes. Same fsel rewrite → cfg_err=0, no drain.
6. (IO_MUX_LOCK_EN) Write addr 14, then write pin 0 fsel=1 → cfg_err=1 and fsel remains 0. Assert rst → lock clears and the write then succeeds.
